// File: rtl/hd63701_irq2_ctrl_pkg.sv
// Shared definitions for the HD63701 IRQ2 request controller.
package hd63701_irq2_ctrl_pkg;

  localparam int unsigned NSRC  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned VN_W  = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PG_W  = 12;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_asrt = 2'd1,
    st_gap  = 2'd2
  } state_t;

  // Source indices, same bit order as REQ/ACK
  localparam logic [IDX_W-1:0] src_ici = 2'd3;
  localparam logic [IDX_W-1:0] src_oci = 2'd2;
  localparam logic [IDX_W-1:0] src_toi = 2'd1;
  localparam logic [IDX_W-1:0] src_sci = 2'd0;

  // Vector low nibbles; the CPU fetches {vec_page, nibble}
  localparam logic [VN_W-1:0] vn_ici = 4'h6;
  localparam logic [VN_W-1:0] vn_oci = 4'h4;
  localparam logic [VN_W-1:0] vn_toi = 4'h2;
  localparam logic [VN_W-1:0] vn_sci = 4'h0;

  localparam logic [PG_W-1:0] vec_page = 12'hFFF;

  // Map a source index to its vector nibble
  function automatic logic [VN_W-1:0] src_vn(input logic [IDX_W-1:0] idx);
    logic [VN_W-1:0] vn;
    case (idx)
      src_ici: vn = vn_ici;
      src_oci: vn = vn_oci;
      src_toi: vn = vn_toi;
      default: vn = vn_sci;
    endcase
    return vn;
  endfunction

endpackage

// File: rtl/hd63701_irq2_prio.sv
// Fixed-priority encoder: ICI > OCI > TOI > SCI.
module hd63701_irq2_prio
  import hd63701_irq2_ctrl_pkg::*;
(
  input  logic [NSRC-1:0]  req,
  output logic             vld_c,
  output logic [IDX_W-1:0] idx_c,
  output logic [VN_W-1:0]  vn_c
);

  // Pick the highest-priority pending source and its nibble
  always_comb begin
    vld_c = |req;
    idx_c = src_sci;
    if (req[src_ici])      idx_c = src_ici;
    else if (req[src_oci]) idx_c = src_oci;
    else if (req[src_toi]) idx_c = src_toi;
    vn_c = src_vn(idx_c);
  end

endmodule

// File: rtl/hd63701_irq2_ctrl.sv
// IRQ2 request side: arbitrates on-chip interrupt flags, presents a
// rising IRQ2 edge with a stable vector nibble, and treats the CPU's
// vector fetch as the acknowledge.
module hd63701_irq2_ctrl
  import hd63701_irq2_ctrl_pkg::*;
#(
  parameter int unsigned GAP = 2
)
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [NSRC-1:0]  REQ,
  input  logic [15:0]      ADR,
  input  logic             RD,
  output logic             IRQ2,
  output logic [VN_W-1:0]  IRQ2V,
  output logic [NSRC-1:0]  ACK,
  output logic             BUSY
);

  state_t           state, state_nxt;
  logic [NSRC-1:0]  served, served_nxt, served_set;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [IDX_W-1:0] win, win_nxt;
  logic             irq2_nxt, busy_nxt;
  logic [VN_W-1:0]  irq2v_nxt;
  logic [NSRC-1:0]  ack_nxt;

  logic [NSRC-1:0]  elig;
  logic             pr_vld;
  logic [IDX_W-1:0] pr_idx;
  logic [VN_W-1:0]  pr_vn;
  logic             ack_hit;

  assign elig = REQ & ~served;

  hd63701_irq2_prio u_prio (
    .req   (elig),
    .vld_c (pr_vld),
    .idx_c (pr_idx),
    .vn_c  (pr_vn)
  );

  // Only the exact fetch of the presented vector's high byte acknowledges
  assign ack_hit = RD && (ADR == {vec_page, IRQ2V});

  // Next-state, served/lockout, gap counter and output decode
  always_comb begin
    state_nxt   = state;
    win_nxt     = win;
    gap_cnt_nxt = gap_cnt;
    irq2v_nxt   = IRQ2V;
    ack_nxt     = '0;
    served_set  = '0;
    case (state)
      st_idle: begin
        if (pr_vld) begin
          win_nxt   = pr_idx;
          irq2v_nxt = pr_vn;
          state_nxt = st_asrt;
        end
      end
      st_asrt: begin
        if (ack_hit) begin
          ack_nxt     = NSRC'(1) << win;
          served_set  = NSRC'(1) << win;
          gap_cnt_nxt = CNT_W'(GAP - 1);
          state_nxt   = st_gap;
        end
      end
      st_gap: begin
        if (gap_cnt == '0) state_nxt = st_idle;
        else               gap_cnt_nxt = gap_cnt - CNT_W'(1);
      end
      default: state_nxt = st_idle;
    endcase
    // A low flag releases its lockout, even on the acknowledge cycle
    served_nxt = (served | served_set) & REQ;
    irq2_nxt   = (state_nxt == st_asrt);
    busy_nxt   = (state_nxt != st_idle);
  end

  // State and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= st_idle;
      served  <= '0;
      gap_cnt <= '0;
      win     <= '0;
      IRQ2    <= 1'b0;
      IRQ2V   <= '0;
      ACK     <= '0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_nxt;
      served  <= served_nxt;
      gap_cnt <= gap_cnt_nxt;
      win     <= win_nxt;
      IRQ2    <= irq2_nxt;
      IRQ2V   <= irq2v_nxt;
      ACK     <= ack_nxt;
      BUSY    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_hd63701_irq2_ctrl.sv
// Scoreboard bench for hd63701_irq2_ctrl: stimulus queues expected
// vectors, acknowledges and status snapshots; a negedge monitor checks.
module tb_hd63701_irq2_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ;
  logic [15:0] ADR;
  logic        RD;
  logic        IRQ2;
  logic [3:0]  IRQ2V;
  logic [3:0]  ACK;
  logic        BUSY;

  hd63701_irq2_ctrl #(.GAP(2)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .ADR   (ADR),
    .RD    (RD),
    .IRQ2  (IRQ2),
    .IRQ2V (IRQ2V),
    .ACK   (ACK),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       irq2;
    logic [3:0] v;
    logic       busy;
    logic [3:0] ack;
  } stat_t;

  logic [3:0] exp_vec[$];
  logic [3:0] exp_ack[$];
  stat_t      exp_stat[$];

  int   total = 0;
  int   bad   = 0;
  logic fin = 1'b0;
  logic mon_done = 1'b0;
  logic irq2_q = 1'b0;

  // Monitor: compares whatever the DUT presents against the queues
  always @(negedge CLK) begin
    stat_t      s;
    logic [3:0] e;
    while (exp_stat.size() > 0) begin
      s = exp_stat.pop_front();
      total++;
      if ({IRQ2, IRQ2V, BUSY, ACK} !== {s.irq2, s.v, s.busy, s.ack}) begin
        bad++;
        $display("FAIL %s: got irq2=%b v=%0d busy=%b ack=%b, want irq2=%b v=%0d busy=%b ack=%b",
                 s.name, IRQ2, IRQ2V, BUSY, ACK, s.irq2, s.v, s.busy, s.ack);
      end
    end
    if (IRQ2 === 1'b1 && irq2_q !== 1'b1) begin
      total++;
      if (exp_vec.size() == 0) begin
        bad++;
        $display("FAIL irq2_edge: unexpected rising edge with IRQ2V=%0d, want none", IRQ2V);
      end else begin
        e = exp_vec.pop_front();
        if (IRQ2V !== e) begin
          bad++;
          $display("FAIL irq2_vec: got IRQ2V=%0d, want %0d", IRQ2V, e);
        end
      end
    end
    irq2_q = IRQ2;
    if (ACK !== 4'b0000) begin
      total++;
      if (exp_ack.size() == 0) begin
        bad++;
        $display("FAIL ack_pulse: unexpected ACK=%b, want none", ACK);
      end else begin
        e = exp_ack.pop_front();
        if (ACK !== e) begin
          bad++;
          $display("FAIL ack_val: got ACK=%b, want %b", ACK, e);
        end
      end
    end
    if (fin && !mon_done) begin
      total++;
      if (exp_vec.size() != 0) begin
        bad++;
        $display("FAIL vec_left: %0d expected IRQ2 edges never seen, want 0", exp_vec.size());
      end
      total++;
      if (exp_ack.size() != 0) begin
        bad++;
        $display("FAIL ack_left: %0d expected ACK pulses never seen, want 0", exp_ack.size());
      end
      mon_done = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic i, input logic [3:0] v,
                     input logic b, input logic [3:0] a);
    stat_t s;
    s.name = nm; s.irq2 = i; s.v = v; s.busy = b; s.ack = a;
    exp_stat.push_back(s);
  endtask

  task automatic do_read(input logic [15:0] a);
    ADR = a;
    RD  = 1'b1;
    tick(1);
    RD  = 1'b0;
    ADR = 16'h0000;
  endtask

  initial begin
    RST = 1'b1; REQ = 4'b0000; ADR = 16'h0000; RD = 1'b0;
    tick(2);
    RST = 1'b0;
    tick(1);
    chk("reset", 1'b0, 4'd0, 1'b0, 4'b0000);

    // Single source, held high after service
    exp_vec.push_back(4'd2);
    REQ = 4'b0010;
    tick(1);
    chk("single_assert", 1'b1, 4'd2, 1'b1, 4'b0000);
    tick(3);
    chk("single_hold", 1'b1, 4'd2, 1'b1, 4'b0000);
    exp_ack.push_back(4'b0010);
    do_read(16'hFFF2);
    chk("single_ack", 1'b0, 4'd2, 1'b1, 4'b0010);
    tick(1);
    chk("single_gap", 1'b0, 4'd2, 1'b1, 4'b0000);
    tick(50);
    chk("single_locked", 1'b0, 4'd2, 1'b0, 4'b0000);
    REQ = 4'b0000;
    tick(2);

    // Priority chain over all four sources
    exp_vec.push_back(4'd6); exp_vec.push_back(4'd4);
    exp_vec.push_back(4'd2); exp_vec.push_back(4'd0);
    REQ = 4'b1111;
    tick(1);
    chk("prio_ici", 1'b1, 4'd6, 1'b1, 4'b0000);
    exp_ack.push_back(4'b1000);
    do_read(16'hFFF6);
    chk("prio_ack_ici", 1'b0, 4'd6, 1'b1, 4'b1000);
    tick(1);
    chk("prio_gap1", 1'b0, 4'd6, 1'b1, 4'b0000);
    tick(1);
    chk("prio_gap2", 1'b0, 4'd6, 1'b0, 4'b0000);
    tick(1);
    chk("prio_oci", 1'b1, 4'd4, 1'b1, 4'b0000);
    exp_ack.push_back(4'b0100);
    do_read(16'hFFF4);
    tick(3);
    chk("prio_toi", 1'b1, 4'd2, 1'b1, 4'b0000);
    exp_ack.push_back(4'b0010);
    do_read(16'hFFF2);
    tick(3);
    chk("prio_sci", 1'b1, 4'd0, 1'b1, 4'b0000);
    exp_ack.push_back(4'b0001);
    do_read(16'hFFF0);
    tick(20);
    chk("prio_done", 1'b0, 4'd0, 1'b0, 4'b0000);
    REQ = 4'b0000;
    tick(2);

    // No preempt, no cancel
    exp_vec.push_back(4'd0);
    REQ = 4'b0001;
    tick(1);
    chk("np_assert", 1'b1, 4'd0, 1'b1, 4'b0000);
    REQ = 4'b1000;
    tick(3);
    chk("np_hold", 1'b1, 4'd0, 1'b1, 4'b0000);
    exp_ack.push_back(4'b0001);
    do_read(16'hFFF0);
    chk("np_ack", 1'b0, 4'd0, 1'b1, 4'b0001);
    exp_vec.push_back(4'd6);
    tick(3);
    chk("np_next", 1'b1, 4'd6, 1'b1, 4'b0000);
    exp_ack.push_back(4'b1000);
    do_read(16'hFFF6);
    REQ = 4'b0000;
    tick(5);
    chk("np_idle", 1'b0, 4'd6, 1'b0, 4'b0000);

    // Non-acknowledging reads while asserted
    exp_vec.push_back(4'd2);
    REQ = 4'b0010;
    tick(1);
    do_read(16'hFFF3);
    chk("nack_fff3", 1'b1, 4'd2, 1'b1, 4'b0000);
    do_read(16'hFFF8);
    chk("nack_fff8", 1'b1, 4'd2, 1'b1, 4'b0000);
    do_read(16'hFFFC);
    chk("nack_fffc", 1'b1, 4'd2, 1'b1, 4'b0000);
    do_read(16'hFFF6);
    chk("nack_fff6", 1'b1, 4'd2, 1'b1, 4'b0000);

    // Re-arm: ack with flag held, one low cycle, flag returns
    exp_ack.push_back(4'b0010);
    do_read(16'hFFF2);
    chk("rearm_ack", 1'b0, 4'd2, 1'b1, 4'b0010);
    tick(1);
    REQ = 4'b0000;
    tick(1);
    REQ = 4'b0010;
    exp_vec.push_back(4'd2);
    tick(1);
    chk("rearm_assert", 1'b1, 4'd2, 1'b1, 4'b0000);
    exp_ack.push_back(4'b0010);
    do_read(16'hFFF2);
    REQ = 4'b0000;
    tick(5);

    // Vector-table reads in IDLE produce nothing
    do_read(16'hFFF2);
    chk("idle_fff2", 1'b0, 4'd2, 1'b0, 4'b0000);
    do_read(16'hFFF6);
    chk("idle_fff6", 1'b0, 4'd2, 1'b0, 4'b0000);
    do_read(16'hFFFC);
    chk("idle_fffc", 1'b0, 4'd2, 1'b0, 4'b0000);
    tick(1);

    // Asynchronous reset while asserted
    exp_vec.push_back(4'd4);
    REQ = 4'b0100;
    tick(1);
    chk("rst_pre", 1'b1, 4'd4, 1'b1, 4'b0000);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    chk("rst_async", 1'b0, 4'd0, 1'b0, 4'b0000);
    REQ = 4'b0000;
    tick(2);
    #2;
    RST = 1'b0;
    tick(10);
    chk("rst_after", 1'b0, 4'd0, 1'b0, 4'b0000);
    tick(2);

    fin = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) tick(1);
    if (!mon_done) begin
      $display("FAIL monitor_timeout: monitor did not finish, want done");
      $fatal(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
